sync_bus_filter: RTL and testbench
==================================

# sync_bus_filter

Multi-channel input synchronizer and stability filter for asynchronous level signals entering a single clock domain (pins, status lines, slow cross-domain flags). Each of WIDTH bits passes through a configurable STAGES-deep synchronizer chain, then a per-channel stability counter that accepts a new level only after FILT consecutive identical synchronized samples. Registered rise, fall and any-change pulses are produced alongside the filtered levels. It is the parametrised successor of the single-bit two-register synchronizers, and is used wherever more than one bit, deeper metastability protection or glitch rejection is needed.

## Interface
- WIDTH, 1: number of independent channels.
- STAGES, 2: synchronizer flops per channel; must be at least 2.
- FILT, 1: consecutive differing synchronized samples required before the output changes; must be at least 1.
- INIT, {WIDTH{1'b0}}: reset and initial value of all synchronizer flops and of dD_OUT.
- Any STAGES < 2 or FILT < 1 fails elaboration.

Ports:
- CLK  input  1  sole clock (destination domain).
- RST  input  1  reset; one clock, reset asynchronous and active-high. Polarity is fixed and does not follow BSV_POSITIVE_RESET.
- sD_IN  input  WIDTH  asynchronous level inputs; no timing relationship to CLK.
- dD_OUT  output  WIDTH  filtered, synchronized levels; reset value INIT.
- dRISE  output  WIDTH  one-cycle pulse per bit when dD_OUT[i] goes 0->1; reset value 0.
- dFALL  output  WIDTH  one-cycle pulse per bit when dD_OUT[i] goes 1->0; reset value 0.
- dCHANGED  output  1  one-cycle pulse when any dD_OUT bit changes, i.e. OR of dRISE|dFALL; registered; reset value 0.

## Operation
- **Synchronizer chain:** sync[0] samples sD_IN; sync[k] samples sync[k-1]. The synchronized value s is sync[STAGES-1]. No logic sits between chain stages.
- **Filter:** each channel has a counter cnt[i] with width $clog2(FILT+1), minimum 1 bit.
  - If s[i] == dD_OUT[i]: cnt[i] <= 0.
  - If s[i] != dD_OUT[i] and cnt[i] == FILT-1: dD_OUT[i] <= s[i] and cnt[i] <= 0.
  - Otherwise: cnt[i] <= cnt[i]+1.
- **FILT == 1** reduces to a plain registered output stage: the output updates on the first edge at which s differs.
- **Pulses:** dRISE, dFALL and dCHANGED are registered and asserted on the same edge that updates dD_OUT, for exactly one cycle. They cannot repeat until a new level has passed the filter.
- **Channel independence:** channels are fully independent. Simultaneous changes on several bits produce simultaneous pulses.
- **Reset:**
  - Asserting RST asynchronously forces all sync flops and dD_OUT to INIT, and all counters and pulses to 0.
  - Any pending filtered change is discarded.
  - After release, a held input needs the full latency again.
  - No pulse is generated by reset itself or by its release.

## Timing
- **Output latency (posedge mode):** counting the edge at which sync[0] first captures the new level as edge 1, dD_OUT changes on edge STAGES+FILT.
- **Pulse timing:** pulses are visible in the cycle following that edge, coincident with the new dD_OUT.
- **Glitch rejection:** a synchronized excursion shorter than FILT cycles never reaches dD_OUT. The counter returns to 0 on the first matching sample.
- **Counter wrap:** cnt never exceeds FILT-1, so no wrap-around occurs.
- **Input requirement:** sD_IN must be stable for at least FILT+1 CLK periods to be guaranteed to propagate.

## Configuration
- Macro `SYNC_BUS_NEGEDGE_FIRST_EN`.
- **Defined:** sync[0] clocks on negedge CLK (with asynchronous RST); all other flops use posedge. Latency becomes STAGES-1+FILT rising edges after the capturing falling edge, a half-cycle saving. sync[0] to sync[1] has a half-period timing budget.
- **Undefined:** all flops are posedge CLK.
- Initial blocks follow the usual BSV_NO_INITIAL_BLOCKS guard: sync, dD_OUT = INIT; counters and pulses = 0.

## Test plan
Bench parameters: WIDTH=4, STAGES=2, FILT=3, INIT=4'h0 unless stated. Edge numbers are rising edges of CLK.

- **Reset values:** RST=1 with sD_IN=4'hF → dD_OUT=4'h0, dRISE=dFALL=0, dCHANGED=0 during reset. Rerun with INIT=4'hA → dD_OUT=4'hA.
- **Single step:** sD_IN[0] 0->1 held, captured on edge 1 → dD_OUT[0]=1 after edge 5; dRISE=4'h1 and dCHANGED=1 for exactly that one cycle. Step back to 0 → dFALL=4'h1 five edges after capture.
- **Glitch rejection:** sD_IN[1] high for exactly 2 CLK periods → dD_OUT stays 4'h0, no pulses. A 3-period pulse → dD_OUT[1] goes high for 3 cycles, with one dRISE and one dFALL.
- **Simultaneous change:** sD_IN 4'h0->4'hF in one cycle → dRISE=4'hF for one cycle and dCHANGED=1 once. Then 4'hF->4'h5 → dFALL=4'hA.
- **Reset mid-filter:** sD_IN[2]=1, RST pulsed high after edge 3 (cnt=1) → dD_OUT returns to 0 immediately with no pulse. After release, dD_OUT[2]=1 exactly 5 edges after the first post-reset capture.
- **Negedge mode:** with `SYNC_BUS_NEGEDGE_FIRST_EN` defined, the step test gives dD_OUT[0]=1 after the 4th rising edge following the capturing falling edge.

Source files
------------

// File: rtl/sync_bus_filter.sv
// sync_bus_filter: per-channel STAGES-deep synchronizer, FILT-sample stability filter and
// registered rise/fall/changed pulses. `SYNC_BUS_NEGEDGE_FIRST_EN clocks the first stage on negedge CLK.
module sync_bus_filter #(
   parameter int               WIDTH  = 1,
   parameter int               STAGES = 2,
   parameter int               FILT   = 1,
   parameter logic [WIDTH-1:0] INIT   = {WIDTH{1'b0}}
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] sD_IN,
   output logic [WIDTH-1:0] dD_OUT,
   output logic [WIDTH-1:0] dRISE,
   output logic [WIDTH-1:0] dFALL,
   output logic             dCHANGED
);
   localparam int            CW       = (FILT > 1) ? $clog2(FILT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(FILT - 1);

   generate
      if (STAGES < 2) begin : gBadStages
         $error("sync_bus_filter: STAGES must be at least 2");
      end
      if (FILT < 1) begin : gBadFilt
         $error("sync_bus_filter: FILT must be at least 1");
      end
   endgenerate

   logic [WIDTH-1:0]              firstReg;
   logic [STAGES-2:0][WIDTH-1:0]  chainReg;
   logic [WIDTH-1:0]              syncVal;
   logic [WIDTH-1:0]              outReg;
   logic [WIDTH-1:0]              outNext;
   logic [WIDTH-1:0][CW-1:0]      cntReg;
   logic [WIDTH-1:0][CW-1:0]      cntNext;
   logic [WIDTH-1:0]              riseReg;
   logic [WIDTH-1:0]              riseNext;
   logic [WIDTH-1:0]              fallReg;
   logic [WIDTH-1:0]              fallNext;
   logic                          changedReg;

   // First capture of the asynchronous input; the only flop allowed to go metastable.
`ifdef SYNC_BUS_NEGEDGE_FIRST_EN
   always_ff @(negedge CLK or posedge RST) begin
`else
   always_ff @(posedge CLK or posedge RST) begin
`endif
      if (RST) begin
         firstReg <= INIT;
      end else begin
         firstReg <= sD_IN;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         chainReg <= {(STAGES-1){INIT}};
      end else begin
         chainReg[0] <= firstReg;
         for (int k = 1; k < STAGES - 1; k++) begin
            chainReg[k] <= chainReg[k-1];
         end
      end
   end

   assign syncVal = chainReg[STAGES-2];

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : gChan
         logic differs;
         logic accept;
         assign differs      = syncVal[gi] != outReg[gi];
         // A channel accepts the new level on the FILT-th consecutive differing sample.
         assign accept       = differs && (cntReg[gi] == CNT_LAST);
         assign cntNext[gi]  = (!differs || accept) ? '0 : cntReg[gi] + CW'(1);
         assign outNext[gi]  = accept ? syncVal[gi] : outReg[gi];
         assign riseNext[gi] = accept & syncVal[gi];
         assign fallNext[gi] = accept & ~syncVal[gi];
      end
   endgenerate

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         outReg     <= INIT;
         cntReg     <= '0;
         riseReg    <= '0;
         fallReg    <= '0;
         changedReg <= 1'b0;
      end else begin
         outReg     <= outNext;
         cntReg     <= cntNext;
         riseReg    <= riseNext;
         fallReg    <= fallNext;
         changedReg <= |(riseNext | fallNext);
      end
   end

   assign dD_OUT   = outReg;
   assign dRISE    = riseReg;
   assign dFALL    = fallReg;
   assign dCHANGED = changedReg;

endmodule

// File: tb/tb_sync_bus_filter.sv
// Scoreboard bench for sync_bus_filter (WIDTH=4, STAGES=2, FILT=3); a run-length reference model
// pushes expected outputs at every rising edge and a monitor pops and compares them 1 ns later.
`timescale 1ns/1ps
module tb_sync_bus_filter;
   localparam int WIDTH  = 4;
   localparam int STAGES = 2;
   localparam int FILT   = 3;
`ifdef SYNC_BUS_NEGEDGE_FIRST_EN
   localparam int MS  = STAGES - 1;
   localparam int LAT = 4;
`else
   localparam int MS  = STAGES;
   localparam int LAT = 5;
`endif

   typedef struct {
      logic [WIDTH-1:0] out;
      logic [WIDTH-1:0] rise;
      logic [WIDTH-1:0] fall;
      logic             chg;
   } exp_t;

   logic             CLK = 1'b0;
   logic             RST = 1'b1;
   logic [WIDTH-1:0] sIn = 4'hF;
   logic [WIDTH-1:0] dD_OUT, dRISE, dFALL;
   logic             dCHANGED;
   logic [WIDTH-1:0] out2, rise2, fall2;
   logic             chg2;

   int checkCount = 0;
   int errCount   = 0;
   exp_t expQ[$];

   logic [WIDTH-1:0] mSync [MS];
   logic [WIDTH-1:0] mOut, mRise, mFall;
   logic             mChg;
   int               mRun [WIDTH];

   sync_bus_filter #(.WIDTH(WIDTH), .STAGES(STAGES), .FILT(FILT), .INIT(4'h0)) dut (
      .CLK(CLK), .RST(RST), .sD_IN(sIn),
      .dD_OUT(dD_OUT), .dRISE(dRISE), .dFALL(dFALL), .dCHANGED(dCHANGED)
   );

   sync_bus_filter #(.WIDTH(WIDTH), .STAGES(STAGES), .FILT(FILT), .INIT(4'hA)) dutInit (
      .CLK(CLK), .RST(RST), .sD_IN(sIn),
      .dD_OUT(out2), .dRISE(rise2), .dFALL(fall2), .dCHANGED(chg2)
   );

   always #5 CLK = ~CLK;

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] want);
      checkCount++;
      if (got !== want) begin
         errCount++;
         $display("FAIL %s: got %0h, want %0h", tag, got, want);
      end
   endtask

   // Reference: a level is accepted after FILT consecutive synchronized samples differ from it.
   task automatic modelStep();
      logic [WIDTH-1:0] s;
      if (RST) begin
         for (int k = 0; k < MS; k++) mSync[k] = '0;
         for (int i = 0; i < WIDTH; i++) mRun[i] = 0;
         mOut  = '0;
         mRise = '0;
         mFall = '0;
         mChg  = 1'b0;
      end else begin
         s = mSync[MS-1];
         for (int k = MS - 1; k > 0; k--) mSync[k] = mSync[k-1];
         mSync[0] = sIn;
         mRise = '0;
         mFall = '0;
         for (int i = 0; i < WIDTH; i++) begin
            if (s[i] == mOut[i]) begin
               mRun[i] = 0;
            end else begin
               mRun[i]++;
               if (mRun[i] == FILT) begin
                  mOut[i] = s[i];
                  mRun[i] = 0;
                  if (s[i]) mRise[i] = 1'b1;
                  else      mFall[i] = 1'b1;
               end
            end
         end
         mChg = |(mRise | mFall);
      end
   endtask

   task automatic tick();
      exp_t e;
      @(posedge CLK);
      modelStep();
      e.out  = mOut;
      e.rise = mRise;
      e.fall = mFall;
      e.chg  = mChg;
      expQ.push_back(e);
      #3;
   endtask

   task automatic waitOut(input logic [WIDTH-1:0] mask, input logic [WIDTH-1:0] want, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (((dD_OUT & mask) !== want) && (n < 20));
   endtask

   // Monitor: compare every DUT output against the expectation pushed at the same edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkEq("sb_out", dD_OUT, e.out);
            checkEq("sb_rise", dRISE, e.rise);
            checkEq("sb_fall", dFALL, e.fall);
            checkEq("sb_chg", dCHANGED, e.chg);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errCount);
      $fatal(1, "timeout");
   end

   initial begin
      int n, rises, falls, highs;
      logic [WIDTH-1:0] seen;

      // Reset with all inputs high.
      repeat (3) tick();
      checkEq("rst_out", dD_OUT, 4'h0);
      checkEq("rst_chg", dCHANGED, 1'b0);
      checkEq("rst_init_out", out2, 4'hA);
      checkEq("rst_init_pulses", {rise2, fall2, 3'b000, chg2}, 12'h000);
      $display("reset: dD_OUT=%0h init-instance=%0h", dD_OUT, out2);
      sIn = 4'h0;
      RST = 1'b0;
      repeat (6) tick();

      // Single step up and back down on bit 0.
      sIn = 4'h1;
      waitOut(4'h1, 4'h1, n);
      checkEq("step_up_lat", n, LAT);
      checkEq("step_up_rise", dRISE, 4'h1);
      checkEq("step_up_chg", dCHANGED, 1'b1);
      tick();
      checkEq("step_up_rise_once", dRISE, 4'h0);
      checkEq("step_up_chg_once", dCHANGED, 1'b0);
      $display("step up: latency %0d edges", n);
      sIn = 4'h0;
      waitOut(4'h1, 4'h0, n);
      checkEq("step_dn_lat", n, LAT);
      checkEq("step_dn_fall", dFALL, 4'h1);
      $display("step down: latency %0d edges", n);
      repeat (4) tick();

      // Two-period glitch on bit 1 must be rejected.
      sIn = 4'h2;
      repeat (2) tick();
      sIn = 4'h0;
      seen = '0;
      rises = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         seen |= dD_OUT;
         rises += int'(dRISE[1]);
      end
      checkEq("glitch2_out", seen, 4'h0);
      checkEq("glitch2_rise", rises, 0);
      $display("glitch 2 periods: seen=%0h rises=%0d", seen, rises);

      // Three-period pulse on bit 1 passes for exactly three cycles.
      sIn = 4'h2;
      rises = 0;
      falls = 0;
      highs = 0;
      for (int c = 0; c < 15; c++) begin
         tick();
         if (c == 2) sIn = 4'h0;
         rises += int'(dRISE[1]);
         falls += int'(dFALL[1]);
         highs += int'(dD_OUT[1]);
      end
      checkEq("pulse3_rise", rises, 1);
      checkEq("pulse3_fall", falls, 1);
      checkEq("pulse3_high", highs, 3);
      $display("pulse 3 periods: high=%0d rises=%0d falls=%0d", highs, rises, falls);

      // Simultaneous change on all channels.
      sIn = 4'hF;
      waitOut(4'hF, 4'hF, n);
      checkEq("simul_lat", n, LAT);
      checkEq("simul_rise", dRISE, 4'hF);
      checkEq("simul_chg", dCHANGED, 1'b1);
      tick();
      checkEq("simul_chg_once", dCHANGED, 1'b0);
      sIn = 4'h5;
      waitOut(4'hF, 4'h5, n);
      checkEq("simul_fall", dFALL, 4'hA);
      checkEq("simul_fall_norise", dRISE, 4'h0);
      $display("simultaneous: rise F then fall %0h", dFALL);

      // Reset in the middle of a pending change.
      sIn = 4'h1;
      waitOut(4'hF, 4'h1, n);
      repeat (2) tick();
      sIn = 4'h5;
      repeat (3) tick();
      RST = 1'b1;
      #1;
      checkEq("midrst_out", dD_OUT, 4'h0);
      checkEq("midrst_pulses", {dRISE, dFALL, 3'b000, dCHANGED}, 12'h000);
      repeat (2) tick();
      RST = 1'b0;
      waitOut(4'hF, 4'h5, n);
      checkEq("midrst_lat", n, LAT);
      checkEq("midrst_rise", dRISE, 4'h5);
      $display("reset mid-filter: relatch latency %0d edges", n);

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end
endmodule
